// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key event arbiter: key level
//                encoding, arbiter FSM state encoding and the event record.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Debounced key level as seen on key_state
    typedef enum logic {
        KEY_PRESSED  = 1'b0,
        KEY_RELEASED = 1'b1
    } key_level_t;

    // Arbiter FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Widest event record supported (16 keys, 32-bit timestamp)
    localparam int KEY_ID_W_MAX = 4;
    localparam int KEY_TS_W_MAX = 32;

    // One key event as it travels from a pending slot to the consumer
    typedef struct packed {
        logic [KEY_ID_W_MAX-1:0] id;
        logic                    press;
        logic [KEY_TS_W_MAX-1:0] ts;
    } key_evt_t;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : key_rr_pick
//  Description : Combinational round-robin selector. Searches the request
//                vector starting one past last_grant, wrapping modulo
//                NUM_KEYS, and returns the first requesting index.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_rr_pick #(
    parameter int NUM_KEYS = 4,
    parameter int IDW      = $clog2(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] i_req,
    input  logic [IDW-1:0]      last_grant,
    output logic                grant_any,
    output logic [IDW-1:0]      grant_idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        int w_idx;
        w_idx     = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = NUM_KEYS; off >= 1; off--) begin
            w_idx = (int'(last_grant) + off) % NUM_KEYS;
            if (i_req[w_idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(w_idx);
            end
        end
    end

endmodule : key_rr_pick
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_arbiter
//  Description : Serialises debounced key events from NUM_KEYS debouncers
//                into one valid/ready stream. One pending slot per key, lossy
//                coalescing with an overflow pulse, round-robin draining into
//                a registered output stage.
//                Optional macro KEY_EVT_TIMESTAMP_EN adds a free-running
//                timestamp captured per event and presented on evt_ts.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_arbiter #(
    parameter int NUM_KEYS = 4,
    parameter int IDW      = $clog2(NUM_KEYS)
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    parameter int TS_W     = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDW-1:0]      evt_id,
    output logic                evt_press,
    output logic                evt_overflow,
    output logic [NUM_KEYS-1:0] pending
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]     evt_ts
`endif
);

    import key_pkg::*;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [0:0]          r_state_q;
    logic [0:0]          w_state_d;

    logic [NUM_KEYS-1:0] r_pend_v_q;
    logic [NUM_KEYS-1:0] w_pend_v_d;
    logic [NUM_KEYS-1:0] r_pend_p_q;
    logic [NUM_KEYS-1:0] w_pend_p_d;
    logic [IDW-1:0]      r_last_grant_q;
    logic [IDW-1:0]      w_last_grant_d;
    logic [IDW-1:0]      r_evt_id_q;
    logic [IDW-1:0]      w_evt_id_d;
    logic                r_evt_press_q;
    logic                w_evt_press_d;
    logic                r_overflow_q;
    logic                w_overflow_d;

    logic                w_grant_any;
    logic [IDW-1:0]      w_grant_idx;
    logic                w_load;

`ifdef KEY_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]     r_ts_cnt_q;
    logic [TS_W-1:0]     w_ts_cnt_d;
    logic [TS_W-1:0]     r_pend_ts_q [NUM_KEYS];
    logic [TS_W-1:0]     w_pend_ts_d [NUM_KEYS];
    logic [TS_W-1:0]     r_evt_ts_q;
    logic [TS_W-1:0]     w_evt_ts_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin selection over registered slot occupancy only
    // ------------------------------------------------------------------
    key_rr_pick #(
        .NUM_KEYS   (NUM_KEYS),
        .IDW        (IDW)
    ) u_rr_pick (
        .i_req      (r_pend_v_q),
        .last_grant (r_last_grant_q),
        .grant_any  (w_grant_any),
        .grant_idx  (w_grant_idx)
    );

    // The output register takes a new event when empty, or when the held one transfers
    always_comb begin
        w_load = w_grant_any && ((r_state_q == ST_IDLE) || evt_ready);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next state: HOLD while an event is presented, IDLE once drained
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (evt_ready && !w_grant_any) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Outputs come straight from flops; nothing combinational from evt_ready
    always_comb begin
        evt_valid    = (r_state_q == ST_HOLD);
        evt_id       = r_evt_id_q;
        evt_press    = r_evt_press_q;
        evt_overflow = r_overflow_q;
        pending      = r_pend_v_q;
`ifdef KEY_EVT_TIMESTAMP_EN
        evt_ts       = r_evt_ts_q;
`endif
    end

    // ------------------------------------------------------------------
    // Pending slots and output stage
    // ------------------------------------------------------------------
    // Drain the granted slot first, then let any new flag claim its slot;
    // a flag landing on a still-occupied, non-granted slot is an overwrite
    always_comb begin
        w_pend_v_d     = r_pend_v_q;
        w_pend_p_d     = r_pend_p_q;
        w_overflow_d   = 1'b0;
        w_last_grant_d = r_last_grant_q;
        w_evt_id_d     = r_evt_id_q;
        w_evt_press_d  = r_evt_press_q;

        if (w_load) begin
            w_pend_v_d[w_grant_idx] = 1'b0;
            w_last_grant_d          = w_grant_idx;
            w_evt_id_d              = w_grant_idx;
            w_evt_press_d           = r_pend_p_q[w_grant_idx];
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_flag[i]) begin
                if (r_pend_v_q[i] && !(w_load && (w_grant_idx == IDW'(i)))) begin
                    w_overflow_d = 1'b1;
                end
                w_pend_v_d[i] = 1'b1;
                w_pend_p_d[i] = (key_state[i] == KEY_PRESSED);
            end
        end
    end

    // Slot and output-stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_v_q     <= '0;
            r_pend_p_q     <= '0;
            r_overflow_q   <= 1'b0;
            r_last_grant_q <= IDW'(NUM_KEYS - 1);
            r_evt_id_q     <= '0;
            r_evt_press_q  <= 1'b0;
        end else begin
            r_pend_v_q     <= w_pend_v_d;
            r_pend_p_q     <= w_pend_p_d;
            r_overflow_q   <= w_overflow_d;
            r_last_grant_q <= w_last_grant_d;
            r_evt_id_q     <= w_evt_id_d;
            r_evt_press_q  <= w_evt_press_d;
        end
    end

`ifdef KEY_EVT_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Timestamp: free-running counter, sampled into a slot on capture
    // ------------------------------------------------------------------
    // Timestamps follow the same drain-then-capture order as the slots
    always_comb begin
        w_ts_cnt_d  = r_ts_cnt_q + TS_W'(1);
        w_pend_ts_d = r_pend_ts_q;
        w_evt_ts_d  = r_evt_ts_q;
        if (w_load) begin
            w_evt_ts_d = r_pend_ts_q[w_grant_idx];
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_flag[i]) begin
                w_pend_ts_d[i] = r_ts_cnt_q;
            end
        end
    end

    // Timestamp registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts_cnt_q <= '0;
            r_evt_ts_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_pend_ts_q[i] <= '0;
            end
        end else begin
            r_ts_cnt_q  <= w_ts_cnt_d;
            r_evt_ts_q  <= w_evt_ts_d;
            r_pend_ts_q <= w_pend_ts_d;
        end
    end
`endif

endmodule : key_event_arbiter
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_arbiter
//  Description : Self-checking bench for key_event_arbiter: directed vector
//                table, hand-written multi-cycle sequences, and randomized
//                traffic compared against an event-level reference model.
//                Honours KEY_EVT_TIMESTAMP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_arbiter;

    import key_pkg::*;

    localparam int NK  = 4;
    localparam int IDW = 2;
`ifdef KEY_EVT_TIMESTAMP_EN
    localparam int TS_W = 16;
`endif

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_flag;
    logic [NK-1:0] key_state;
    logic          evt_valid;
    logic          evt_ready;
    logic [IDW-1:0] evt_id;
    logic          evt_press;
    logic          evt_overflow;
    logic [NK-1:0] pending;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] evt_ts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    key_event_arbiter #(
        .NUM_KEYS     (NK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_press    (evt_press),
        .evt_overflow (evt_overflow),
        .pending      (pending)
`ifdef KEY_EVT_TIMESTAMP_EN
        ,
        .evt_ts       (evt_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: one slot per key, a held output event, and a
    // round-robin pointer. Updated once per clock from the applied inputs.
    // ------------------------------------------------------------------
    bit       m_pv  [NK];
    bit       m_pp  [NK];
    int       m_pts [NK];
    int       m_last;
    bit       m_valid;
    key_evt_t m_out;
    bit       m_ovf;
    int       m_cnt;

    function automatic void model_step(bit rst, logic [NK-1:0] flg, logic [NK-1:0] st, bit rdy);
        int pick;
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                m_pv[k] = 0; m_pp[k] = 0; m_pts[k] = 0;
            end
            m_last  = NK - 1;
            m_valid = 0;
            m_out   = '0;
            m_ovf   = 0;
            m_cnt   = 0;
            return;
        end
        pick = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= NK; k++) begin
                if (pick < 0 && m_pv[(m_last + k) % NK]) pick = (m_last + k) % NK;
            end
            if (pick >= 0) begin
                m_valid     = 1;
                m_out.id    = 4'(pick);
                m_out.press = m_pp[pick];
                m_out.ts    = 32'(m_pts[pick]);
                m_pv[pick]  = 0;
                m_last      = pick;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf = 0;
        for (int k = 0; k < NK; k++) begin
            if (flg[k]) begin
                if (m_pv[k]) m_ovf = 1;
                m_pv[k]  = 1;
                m_pp[k]  = (st[k] == 1'b0);
                m_pts[k] = m_cnt;
            end
        end
        m_cnt = (m_cnt + 1) % 65536;
    endfunction

    function automatic logic [NK-1:0] model_pending();
        logic [NK-1:0] p;
        for (int k = 0; k < NK; k++) p[k] = m_pv[k];
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge
    task automatic tick(input bit rst, input logic [NK-1:0] flg, input logic [NK-1:0] st, input bit rdy);
        reset     = rst;
        key_flag  = flg;
        key_state = st;
        evt_ready = rdy;
        @(posedge clk);
        model_step(rst, flg, st, rdy);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'(m_valid));
        check({tag, "_pending"}, 32'(pending), 32'(model_pending()));
        check({tag, "_ovf"}, 32'(evt_overflow), 32'(m_ovf));
        if (m_valid) begin
            check({tag, "_id"}, 32'(evt_id), 32'(m_out.id));
            check({tag, "_press"}, 32'(evt_press), 32'(m_out.press));
`ifdef KEY_EVT_TIMESTAMP_EN
            check({tag, "_ts"}, 32'(evt_ts), m_out.ts);
`endif
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            rst;
        logic [NK-1:0] flg;
        logic [NK-1:0] st;
        bit            rdy;
        bit            v;
        int            id;
        bit            p;
        bit            ovf;
        logic [NK-1:0] pend;
    } vec_t;

    vec_t vecs [18];

    initial begin
        // single press on key 2
        vecs[0]  = '{1, 4'b0000, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        vecs[1]  = '{0, 4'b0100, 4'b1011, 1, 0, 0, 0, 0, 4'b0100};
        vecs[2]  = '{0, 4'b0000, 4'b1111, 1, 1, 2, 1, 0, 4'b0000};
        vecs[3]  = '{0, 4'b0000, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        // simultaneous flags on 0,1,3 from reset; key 1 is a release
        vecs[4]  = '{1, 4'b0000, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        vecs[5]  = '{0, 4'b1011, 4'b0110, 1, 0, 0, 0, 0, 4'b1011};
        vecs[6]  = '{0, 4'b0000, 4'b1111, 1, 1, 0, 1, 0, 4'b1010};
        vecs[7]  = '{0, 4'b0000, 4'b1111, 1, 1, 1, 0, 0, 4'b1000};
        vecs[8]  = '{0, 4'b0000, 4'b1111, 1, 1, 3, 1, 0, 4'b0000};
        vecs[9]  = '{0, 4'b0000, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        // overwrite on key 1 while key 0 is held
        vecs[10] = '{0, 4'b0001, 4'b1110, 0, 0, 0, 0, 0, 4'b0001};
        vecs[11] = '{0, 4'b0000, 4'b1111, 0, 1, 0, 1, 0, 4'b0000};
        vecs[12] = '{0, 4'b0010, 4'b1101, 0, 1, 0, 1, 0, 4'b0010};
        vecs[13] = '{0, 4'b0010, 4'b1111, 0, 1, 0, 1, 1, 4'b0010};
        vecs[14] = '{0, 4'b0000, 4'b1111, 0, 1, 0, 1, 0, 4'b0010};
        vecs[15] = '{0, 4'b0000, 4'b1111, 1, 1, 1, 0, 0, 4'b0000};
        vecs[16] = '{0, 4'b0000, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        // grant-capture: key 2 re-flagged in the cycle it is granted
        vecs[17] = '{0, 4'b0100, 4'b1011, 1, 0, 0, 0, 0, 4'b0100};
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int exp_id;
        reset     = 1'b1;
        key_flag  = '0;
        key_state = '1;
        evt_ready = 1'b0;
        #1;

        for (int t = 0; t < 18; t++) begin
            tick(vecs[t].rst, vecs[t].flg, vecs[t].st, vecs[t].rdy);
            check($sformatf("vec%0d_valid", t), 32'(evt_valid), 32'(vecs[t].v));
            check($sformatf("vec%0d_pending", t), 32'(pending), 32'(vecs[t].pend));
            check($sformatf("vec%0d_ovf", t), 32'(evt_overflow), 32'(vecs[t].ovf));
            if (vecs[t].v || vecs[t].rst) begin
                check($sformatf("vec%0d_id", t), 32'(evt_id), 32'(vecs[t].id));
                check($sformatf("vec%0d_press", t), 32'(evt_press), 32'(vecs[t].p));
            end
`ifdef KEY_EVT_TIMESTAMP_EN
            if (vecs[t].rst) check($sformatf("vec%0d_ts", t), 32'(evt_ts), 0);
`endif
        end

        // grant-capture continued: key 2 granted while re-flagged -> no overflow
        tick(0, 4'b0100, 4'b1111, 1);
        check("gcap_valid", 32'(evt_valid), 1);
        check("gcap_id", 32'(evt_id), 2);
        check("gcap_press", 32'(evt_press), 1);
        check("gcap_ovf", 32'(evt_overflow), 0);
        check("gcap_pending", 32'(pending), 32'(4'b0100));
        tick(0, 4'b0000, 4'b1111, 1);
        check("gcap2_id", 32'(evt_id), 2);
        check("gcap2_press", 32'(evt_press), 0);
        tick(0, 4'b0000, 4'b1111, 1);
        check("gcap3_valid", 32'(evt_valid), 0);

        // backpressure: hold key 2 for 10 stalled cycles, then one transfer
        tick(0, 4'b0100, 4'b1011, 0);
        tick(0, 4'b0000, 4'b1111, 0);
        for (int c = 0; c < 10; c++) begin
            tick(0, 4'b0000, 4'b1111, 0);
            check("bp_valid", 32'(evt_valid), 1);
            check("bp_id", 32'(evt_id), 2);
            check("bp_press", 32'(evt_press), 1);
            compare_model("bp");
        end
        tick(0, 4'b0000, 4'b1111, 1);
        check("bp_release_valid", 32'(evt_valid), 0);

        // fairness and wrap: all keys re-flagged every cycle
        tick(1, 4'b0000, 4'b1111, 1);
        tick(0, 4'b1111, 4'b0000, 1);
        for (int k = 0; k < 8; k++) begin
            tick(0, 4'b1111, 4'b0000, 1);
            exp_id = k % NK;
            check($sformatf("fair%0d_valid", k), 32'(evt_valid), 1);
            check($sformatf("fair%0d_id", k), 32'(evt_id), 32'(exp_id));
            compare_model("fair");
        end

        // reset while holding key 1 with keys 2,3 still pending
        tick(1, 4'b0000, 4'b1111, 0);
        tick(0, 4'b1110, 4'b0000, 0);
        tick(0, 4'b0000, 4'b1111, 0);
        check("rst_pre_valid", 32'(evt_valid), 1);
        check("rst_pre_pending", 32'(pending), 32'(4'b1100));
        tick(1, 4'b0000, 4'b1111, 1);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id", 32'(evt_id), 0);
        check("rst_press", 32'(evt_press), 0);
        check("rst_ovf", 32'(evt_overflow), 0);
        check("rst_pending", 32'(pending), 0);
`ifdef KEY_EVT_TIMESTAMP_EN
        check("rst_ts", 32'(evt_ts), 0);
`endif
        tick(0, 4'b1000, 4'b0111, 1);
        check("rst_k3_pending", 32'(pending), 32'(4'b1000));
        tick(0, 4'b0000, 4'b1111, 1);
        check("rst_k3_valid", 32'(evt_valid), 1);
        check("rst_k3_id", 32'(evt_id), 3);
        check("rst_k3_press", 32'(evt_press), 1);
`ifdef KEY_EVT_TIMESTAMP_EN
        check("rst_k3_ts", 32'(evt_ts), 0);
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(0, 299) == 0),
                 NK'($urandom & $urandom & $urandom),
                 NK'($urandom),
                 ($urandom_range(0, 3) != 0));
            compare_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_event_arbiter
`default_nettype wire
